mem_wb_stage: RTL
=================

# mem_wb_stage

Dual-lane MEM/WB pipeline stage of the superscalar pipeline, directly downstream of the memory stage and its cache. It selects each lane's writeback result (ALU output or load data), registers it into the W stage and generates the pipeline stall on a cache miss. A miss-service state machine covers the fill penalty, plus an extra eviction penalty when the victim line is dirty. During the penalty the stage injects bubbles into writeback, then replays the held access.

## Interface
- MISS_CYCLES, 4: fill penalty per missing lane, in cycles (≥1).
- DIRTY_CYCLES, 4: extra eviction penalty when `dirty` is seen with a miss (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- memtoregm, memtoregm2  in  1  lane 1/2 result is load data (else ALU output).
- regwritem, regwritem2  in  1  lane 1/2 writes the register file.
- writeregm, writeregm2  in  5  lane 1/2 destination register.
- aluoutm, aluoutm2  in  32  lane 1/2 ALU result.
- readdatam, readdatam2  in  32  lane 1/2 load data from the memory system.
- hit, hit2, miss, miss2, dirty  in  1  cache status from the memory system.
- regwritew, regwritew2  out  1  W-stage write enables.
- writeregw, writeregw2  out  5  W-stage destinations.
- resultw, resultw2  out  32  W-stage results.
- stallm  out  1  combinational; freezes F/D/E/M pipeline registers.
- misscount  out  16  cycles spent in miss service (see Configuration).

## Operation
- States: RUN, EVICT, FILL1, FILL2. 5-bit down-counter `cnt` and 1-bit `replay` flag.
- RUN, replay=0, miss=0, miss2=0: capture both lanes into W.
  - resultw = memtoregm ? readdatam : aluoutm; same for lane 2.
  - Writes to register 0 are suppressed (regwritew=0).
  - Same-destination squash: if both lanes write the same nonzero register, regwritew=0 and lane 2 wins.
- RUN, replay=0, miss or miss2:
  - stallm=1; W loads a bubble (both regwritew=0).
  - Next state: EVICT (cnt=DIRTY_CYCLES-1) if dirty, else FILL1 if miss, else FILL2; fill states load cnt=MISS_CYCLES-1.
  - `pend2` latches miss2 when lane 1 also missed.
- EVICT: cnt==0 → FILL1 if lane 1 missed, else FILL2.
- FILL1: cnt==0 → FILL2 if pend2, else RUN with replay=1.
- FILL2: cnt==0 → RUN with replay=1; clears pend2.
- In EVICT, FILL1 and FILL2: stallm=1, W loads a bubble, cnt decrements each cycle, and hit/miss/dirty are ignored.
- RUN, replay=1: miss/miss2 ignored; stallm=0; both lanes captured as in normal RUN; replay cleared. This guarantees forward progress.
- hit/hit2 are informational only; the stall decision uses miss/miss2 alone.

## Timing
- Result latency: M inputs → W outputs, 1 clock.
- Clean single-lane miss stall: stallm high for 1 + MISS_CYCLES cycles; the replay cycle follows with stallm=0.
- Dirty miss on both lanes: 1 + DIRTY_CYCLES + 2·MISS_CYCLES stall cycles.
- stallm = (state≠RUN) | (state==RUN & ~replay & (miss|miss2)); no register in the path.
- Reset (asynchronous, any state, including mid-fill):
  - state=RUN, replay=0, pend2=0, cnt=0, misscount=0.
  - regwritew=regwritew2=0, writeregw=writeregw2=0, resultw=resultw2=0.
  - stallm follows its equation from RUN immediately.
- misscount saturates at 16'hFFFF; it never wraps.

## Configuration
- MEM_MISS_COUNTER_EN defined: misscount increments once per cycle in which stallm=1 (saturating at 16'hFFFF); it clears only on reset.
- MEM_MISS_COUNTER_EN undefined: the counter logic is not compiled; misscount is tied to 16'h0000. The port remains in both builds.

## Test plan
- Hit path: aluoutm=32'h10, memtoregm=0, regwritem=1, writeregm=5; lane 2 load readdatam2=32'hBEEF, writeregm2=6 → next cycle resultw=32'h10/w5 and resultw2=32'hBEEF/w6, stallm=0 throughout.
- Clean miss, MISS_CYCLES=4: miss=1, dirty=0 → stallm=1 for 5 cycles with both regwritew=0; the replay cycle captures readdatam with miss still 1; misscount=5.
- Dirty dual miss, DIRTY_CYCLES=4, MISS_CYCLES=4: miss=miss2=dirty=1 → state sequence EVICT×4, FILL1×4, FILL2×4; stallm=1 for 13 cycles, then replay.
- Conflict and r0: both lanes write register 7 with values 1 and 2 → regwritew=0, regwritew2=1, resultw2=2. writeregm=0 → regwritew=0.
- Reset mid-fill: assert rst_n=0 in cycle 2 of FILL1 → all outputs 0 and state RUN asynchronously; after release with miss=0, stallm=0 and normal capture resumes.
- Build without MEM_MISS_COUNTER_EN: rerun the clean-miss test → misscount stays 0; all other outputs are identical to the enabled build.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Dual-lane MEM/WB stage: writeback select, cache-miss stall FSM with eviction/fill penalties and replay.
// Optional feature: define MEM_MISS_COUNTER_EN to build the saturating stall-cycle counter on misscount.
module mem_wb_stage #(
    parameter int MISS_CYCLES  = 4,
    parameter int DIRTY_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memtoregm,
    input  logic        memtoregm2,
    input  logic        regwritem,
    input  logic        regwritem2,
    input  logic [4:0]  writeregm,
    input  logic [4:0]  writeregm2,
    input  logic [31:0] aluoutm,
    input  logic [31:0] aluoutm2,
    input  logic [31:0] readdatam,
    input  logic [31:0] readdatam2,
    input  logic        hit,
    input  logic        hit2,
    input  logic        miss,
    input  logic        miss2,
    input  logic        dirty,
    output logic        regwritew,
    output logic        regwritew2,
    output logic [4:0]  writeregw,
    output logic [4:0]  writeregw2,
    output logic [31:0] resultw,
    output logic [31:0] resultw2,
    output logic        stallm,
    output logic [15:0] misscount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        EVICT = 2'd1,
        FILL1 = 2'd2,
        FILL2 = 2'd3
    } state_t;

    localparam logic [4:0] MISS_LOAD  = 5'(MISS_CYCLES - 1);
    localparam logic [4:0] DIRTY_LOAD = 5'(DIRTY_CYCLES - 1);

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic        replay_r;
    logic        pend1_r;
    logic        pend2_r;

    logic        miss_start_s;
    logic        capture_s;
    logic        cnt_zero_s;
    logic        squash_s;
    logic        wen1_s;
    logic        wen2_s;
    logic [31:0] res1_s;
    logic [31:0] res2_s;
    logic        unused_s;

    // hit/hit2 carry no decision weight; the stall is driven by miss/miss2 only
    assign unused_s = ^{hit, hit2};

    // Stall decode and lane result selection
    always_comb begin
        miss_start_s = 1'b0;
        capture_s    = 1'b0;
        if (state_r == RUN) begin
            miss_start_s = ~replay_r & (miss | miss2);
            capture_s    = ~miss_start_s;
        end else begin
            miss_start_s = 1'b0;
            capture_s    = 1'b0;
        end
        stallm     = (state_r != RUN) | miss_start_s;
        cnt_zero_s = (cnt_r == 5'd0);
        squash_s   = regwritem & regwritem2 & (writeregm == writeregm2) & (writeregm != 5'd0);
        wen1_s     = regwritem & (writeregm != 5'd0) & ~squash_s;
        wen2_s     = regwritem2 & (writeregm2 != 5'd0);
        res1_s     = memtoregm ? readdatam : aluoutm;
        res2_s     = memtoregm2 ? readdatam2 : aluoutm2;
    end

    // Miss-service state machine: penalty countdown, pending lanes and replay flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            cnt_r    <= 5'd0;
            replay_r <= 1'b0;
            pend1_r  <= 1'b0;
            pend2_r  <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (replay_r) begin
                        replay_r <= 1'b0;
                    end else if (miss | miss2) begin
                        pend1_r <= miss;
                        pend2_r <= miss & miss2;
                        if (dirty) begin
                            state_r <= EVICT;
                            cnt_r   <= DIRTY_LOAD;
                        end else if (miss) begin
                            state_r <= FILL1;
                            cnt_r   <= MISS_LOAD;
                        end else begin
                            state_r <= FILL2;
                            cnt_r   <= MISS_LOAD;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                EVICT: begin
                    if (cnt_zero_s) begin
                        state_r <= pend1_r ? FILL1 : FILL2;
                        cnt_r   <= MISS_LOAD;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                FILL1: begin
                    if (cnt_zero_s) begin
                        pend1_r <= 1'b0;
                        if (pend2_r) begin
                            state_r <= FILL2;
                            cnt_r   <= MISS_LOAD;
                        end else begin
                            state_r  <= RUN;
                            replay_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                FILL2: begin
                    if (cnt_zero_s) begin
                        state_r  <= RUN;
                        replay_r <= 1'b1;
                        pend1_r  <= 1'b0;
                        pend2_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    cnt_r    <= 5'd0;
                    replay_r <= 1'b0;
                    pend1_r  <= 1'b0;
                    pend2_r  <= 1'b0;
                end
            endcase
        end
    end

    // W-stage registers: capture both lanes, or load a bubble while stalling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwritew  <= 1'b0;
            regwritew2 <= 1'b0;
            writeregw  <= 5'd0;
            writeregw2 <= 5'd0;
            resultw    <= 32'd0;
            resultw2   <= 32'd0;
        end else if (capture_s) begin
            regwritew  <= wen1_s;
            regwritew2 <= wen2_s;
            writeregw  <= writeregm;
            writeregw2 <= writeregm2;
            resultw    <= res1_s;
            resultw2   <= res2_s;
        end else begin
            regwritew  <= 1'b0;
            regwritew2 <= 1'b0;
        end
    end

`ifdef MEM_MISS_COUNTER_EN
    logic [15:0] misscount_r;

    // Saturating count of stalled cycles; cleared by reset only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misscount_r <= 16'd0;
        end else if (stallm && (misscount_r != 16'hFFFF)) begin
            misscount_r <= misscount_r + 16'd1;
        end else begin
            misscount_r <= misscount_r;
        end
    end

    assign misscount = misscount_r;
`else
    assign misscount = 16'h0000;
`endif

endmodule
